ft_recovery: RTL

FT_RECOVERY -- requirements
Module: ft_recovery

---
 rtl/ft_pkg.sv | 16 +
 rtl/ft_recovery_if.sv | 37 +++
 rtl/ft_recovery.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and constants for the fault-tolerant recovery unit
package ft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DRAIN       = 3'd1,
    ST_RESTORE     = 3'd2,
    ST_REDIRECT    = 3'd3,
    ST_WAIT_RESUME = 3'd4
  } ft_rec_state_e;

  localparam int FT_REC_CNT_W      = 8;
  localparam int FT_REC_FIRST_ADDR = 1;
  localparam int FT_REC_DRAIN_W    = 4;

endpackage

// File: rtl/ft_recovery_if.sv
// rtl/ft_recovery_if.sv - signal bundle between the recovery unit and the redundant cores
interface ft_recovery_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                    halt;
  logic                    resume;
  logic [DATA_WIDTH-1:0]   spc;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    fetch_block;
  logic                    flush;
  logic                    rf_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    pc_we;
  logic [DATA_WIDTH-1:0]   pc;
  logic                    busy;
  logic                    done;
  logic [FT_REC_CNT_W-1:0] recovery_cnt;

  // master: the recovery unit; slave: fault-tolerance module, shadow GPR and cores
  modport master (
    input  halt, resume, spc, rdata,
    output raddr, fetch_block, flush, rf_we, rf_waddr, rf_wdata,
           pc_we, pc, busy, done, recovery_cnt
  );

  modport slave (
    output halt, resume, spc, rdata,
    input  raddr, fetch_block, flush, rf_we, rf_waddr, rf_wdata,
           pc_we, pc, busy, done, recovery_cnt
  );

endinterface

// File: rtl/ft_recovery.sv
// rtl/ft_recovery.sv - halts both cores, drains, restores GPRs from the shadow copy and redirects the PC
module ft_recovery
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    halt_i,
  input  logic                    resume_i,
  input  logic [DATA_WIDTH-1:0]   spc_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  output logic [ADDR_WIDTH-1:0]   raddr_o,
  output logic                    fetch_block_o,
  output logic                    flush_o,
  output logic                    rf_we_o,
  output logic [ADDR_WIDTH-1:0]   rf_waddr_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic                    pc_we_o,
  output logic [DATA_WIDTH-1:0]   pc_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [FT_REC_CNT_W-1:0] recovery_cnt_o
);

  localparam logic [FT_REC_DRAIN_W-1:0] DRAIN_LOAD = FT_REC_DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]     IDX_FIRST  = ADDR_WIDTH'(FT_REC_FIRST_ADDR);
  localparam logic [ADDR_WIDTH-1:0]     IDX_LAST   = '1;
  localparam logic [FT_REC_CNT_W-1:0]   CNT_MAX    = '1;

  ft_rec_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [FT_REC_DRAIN_W-1:0] drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic                      pend_q, pend_d;
  logic [FT_REC_CNT_W-1:0]   cnt_q, cnt_d;
  logic                      done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    // A halt in any state (re)starts recovery and swallows a simultaneous resume.
    if (halt_i) begin
      state_d = ST_DRAIN;
      pc_d    = spc_i;
      drain_d = DRAIN_LOAD;
      pend_d  = 1'b0;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      unique case (state_q)
        ST_DRAIN: begin
          if (resume_i) pend_d = 1'b1;
          if (drain_q == '0) begin
            state_d = ST_RESTORE;
            idx_d   = IDX_FIRST;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        ST_RESTORE: begin
          if (resume_i) pend_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_REDIRECT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (resume_i) pend_d = 1'b1;
          state_d = ST_WAIT_RESUME;
        end
        ST_WAIT_RESUME: begin
          if (resume_i || pend_q) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic in_restore;
  assign in_restore = (state_q == ST_RESTORE);

  // The counter only equals its load value in the first cycle after entering DRAIN.
  assign flush_o        = (state_q == ST_DRAIN) && (drain_q == DRAIN_LOAD);
  assign busy_o         = (state_q != ST_IDLE);
  assign fetch_block_o  = busy_o;
  assign raddr_o        = in_restore ? idx_q : '0;
  assign rf_we_o        = in_restore;
  assign rf_waddr_o     = in_restore ? idx_q : '0;
  assign rf_wdata_o     = in_restore ? rdata_i : '0;
  assign pc_we_o        = (state_q == ST_REDIRECT);
  assign pc_o           = pc_we_o ? pc_q : '0;
  assign done_o         = done_q;
  assign recovery_cnt_o = cnt_q;

endmodule
